// File: rtl/clint_pkg.sv
// Shared CLINT constants: address window, default mtime offsets, AXI response codes.
package clint_pkg;

    localparam logic [31:0] CLINT_BASE        = 32'h0200_0000;
    localparam logic [31:0] CLINT_WINDOW_MASK = 32'h0000_FFFF;

    localparam logic [15:0] MTIME_LO_OFF_DEFAULT = 16'hBFF8;
    localparam logic [15:0] MTIME_HI_OFF_DEFAULT = 16'hBFFC;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } clint_state_e;

endpackage

// File: rtl/clint_mtime.sv
// Free-running 64-bit mtime counter advanced once every MTIME_DIV clock cycles.
module clint_mtime #(
    parameter int unsigned MTIME_DIV = 1
) (
    input  logic        clock,
    input  logic        reset,
    output logic [63:0] mtime
);

    localparam logic [15:0] DIV_LAST = 16'(MTIME_DIV - 1);

    logic [15:0] div_cnt;

    // The prescaler wrap and the mtime step share one edge, so a divide of 1 counts every cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
            mtime   <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            mtime   <= mtime + 64'd1;
        end else begin
            div_cnt <= div_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/clint.sv
// Read-only AXI4 responder exposing the CLINT mtime counter; one read in flight at a time.
module clint
    import clint_pkg::*;
#(
    parameter int unsigned MTIME_DIV    = 1,
    parameter logic [15:0] MTIME_LO_OFF = MTIME_LO_OFF_DEFAULT,
    parameter logic [15:0] MTIME_HI_OFF = MTIME_HI_OFF_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] araddr_i,
    input  logic        arvalid_i,
    output logic        arready_o,
    output logic        rvalid_o,
    input  logic        rready_i,
    output logic [63:0] rdata_o,
    output logic [1:0]  rresp_o,
    output logic        rlast_o,
    output logic [3:0]  rid_o
);

    clint_state_e state;
    logic [63:0]  mtime;
    logic [63:0]  rdata_q;
    logic [1:0]   rresp_q;
    logic [31:0]  win_offset;
    logic         offset_hit;

    clint_mtime #(
        .MTIME_DIV(MTIME_DIV)
    ) u_mtime (
        .clock(clock),
        .reset(reset),
        .mtime(mtime)
    );

    assign win_offset = araddr_i & CLINT_WINDOW_MASK;
    assign offset_hit = (win_offset == {16'h0, MTIME_LO_OFF}) ||
                        (win_offset == {16'h0, MTIME_HI_OFF});

    // Response registers are cleared on the R handshake so idle outputs read as zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            rdata_q <= '0;
            rresp_q <= AXI_RESP_OKAY;
        end else begin
            case (state)
                IDLE: begin
                    if (arvalid_i) begin
                        state   <= RESP;
                        rdata_q <= offset_hit ? mtime : 64'h0;
                        rresp_q <= offset_hit ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
                    end
                end
                RESP: begin
                    if (rready_i) begin
                        state   <= IDLE;
                        rdata_q <= '0;
                        rresp_q <= AXI_RESP_OKAY;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign arready_o = (state == IDLE);
    assign rvalid_o  = (state == RESP);
    assign rlast_o   = (state == RESP);
    assign rdata_o   = rdata_q;
    assign rresp_o   = rresp_q;
    assign rid_o     = 4'h0;

endmodule

// File: tb/tb_clint.sv
// Directed self-checking bench for clint with a divide-by-1 and a divide-by-4 instance.
module tb_clint;
    import clint_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic [31:0] a_araddr = '0;
    logic        a_arvalid = 1'b0;
    logic        a_arready;
    logic        a_rvalid;
    logic        a_rready = 1'b0;
    logic [63:0] a_rdata;
    logic [1:0]  a_rresp;
    logic        a_rlast;
    logic [3:0]  a_rid;

    logic [31:0] b_araddr = '0;
    logic        b_arvalid = 1'b0;
    logic        b_arready;
    logic        b_rvalid;
    logic        b_rready = 1'b0;
    logic [63:0] b_rdata;
    logic [1:0]  b_rresp;
    logic        b_rlast;
    logic [3:0]  b_rid;

    int n_compared = 0;
    int n_mismatched = 0;
    int cyc;

    localparam logic [31:0] ADDR_LO  = CLINT_BASE + 32'h0000_BFF8;
    localparam logic [31:0] ADDR_HI  = CLINT_BASE + 32'h0000_BFFC;
    localparam logic [31:0] ADDR_BAD = CLINT_BASE + 32'h0000_4000;

    clint #(.MTIME_DIV(1)) dut1 (
        .clock(clock), .reset(reset),
        .araddr_i(a_araddr), .arvalid_i(a_arvalid), .arready_o(a_arready),
        .rvalid_o(a_rvalid), .rready_i(a_rready), .rdata_o(a_rdata),
        .rresp_o(a_rresp), .rlast_o(a_rlast), .rid_o(a_rid)
    );

    clint #(.MTIME_DIV(4)) dut4 (
        .clock(clock), .reset(reset),
        .araddr_i(b_araddr), .arvalid_i(b_arvalid), .arready_o(b_arready),
        .rvalid_o(b_rvalid), .rready_i(b_rready), .rdata_o(b_rdata),
        .rresp_o(b_rresp), .rlast_o(b_rlast), .rid_o(b_rid)
    );

    always #5 clock = ~clock;

    // Cycle index since reset release: after the k-th rising edge cyc == k.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic wait_cycle(input int n);
        while (cyc < n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset();
        a_arvalid = 1'b0; a_rready = 1'b0; b_arvalid = 1'b0; b_rready = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
    endtask

    task automatic test_reset();
        a_arvalid = 1'b0; a_rready = 1'b0; b_arvalid = 1'b0; b_rready = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        n_compared++;
        if (a_arready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL reset_arready: got %b want 1", a_arready); end
        n_compared++;
        if (a_rvalid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_rvalid: got %b want 0", a_rvalid); end
        n_compared++;
        if (a_rdata !== 64'h0) begin n_mismatched++; $display("[TB] FAIL reset_rdata: got %h want 0", a_rdata); end
        n_compared++;
        if ({a_rresp, a_rlast, a_rid} !== 7'h0) begin n_mismatched++; $display("[TB] FAIL reset_resp_last_id: got %h want 0", {a_rresp, a_rlast, a_rid}); end
        n_compared++;
        if (dut1.u_mtime.mtime !== 64'h0) begin n_mismatched++; $display("[TB] FAIL reset_mtime: got %h want 0", dut1.u_mtime.mtime); end
        reset = 1'b1;
        wait_cycle(3);
        n_compared++;
        if (dut1.u_mtime.mtime !== 64'd3) begin n_mismatched++; $display("[TB] FAIL div1_first_steps: got %0d want 3", dut1.u_mtime.mtime); end
        n_compared++;
        if (dut4.u_mtime.mtime !== 64'd0) begin n_mismatched++; $display("[TB] FAIL div4_before_step: got %0d want 0", dut4.u_mtime.mtime); end
        wait_cycle(4);
        n_compared++;
        if (dut4.u_mtime.mtime !== 64'd1) begin n_mismatched++; $display("[TB] FAIL div4_first_step: got %0d want 1", dut4.u_mtime.mtime); end
    endtask

    task automatic test_single_read();
        do_reset();
        wait_cycle(10);
        a_araddr = ADDR_LO; a_arvalid = 1'b1;
        n_compared++;
        if (a_arready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL single_arready: got %b want 1", a_arready); end
        @(posedge clock); #1;
        a_arvalid = 1'b0;
        n_compared++;
        if (a_rvalid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL single_rvalid: got %b want 1", a_rvalid); end
        n_compared++;
        if (a_rdata !== 64'd10) begin n_mismatched++; $display("[TB] FAIL single_rdata: got %0d want 10", a_rdata); end
        n_compared++;
        if ({a_rresp, a_rlast, a_rid} !== 7'b00_1_0000) begin n_mismatched++; $display("[TB] FAIL single_resp_last_id: got %b want 0010000", {a_rresp, a_rlast, a_rid}); end
        a_rready = 1'b1;
        @(posedge clock); #1;
        a_rready = 1'b0;
        n_compared++;
        if ({a_rvalid, a_arready} !== 2'b01) begin n_mismatched++; $display("[TB] FAIL single_back_to_idle: got %b want 01", {a_rvalid, a_arready}); end
        n_compared++;
        if ({a_rdata, a_rresp, a_rlast} !== 67'h0) begin n_mismatched++; $display("[TB] FAIL single_idle_zero: got %h want 0", {a_rdata, a_rresp, a_rlast}); end
    endtask

    task automatic test_stall();
        do_reset();
        wait_cycle(10);
        a_araddr = ADDR_LO; a_arvalid = 1'b1;
        @(posedge clock); #1;
        a_araddr = ADDR_HI;
        for (int i = 0; i < 5; i++) begin
            n_compared++;
            if ({a_rvalid, a_arready, a_rdata} !== {2'b10, 64'd10}) begin
                n_mismatched++;
                $display("[TB] FAIL stall_hold_%0d: got rvalid=%b arready=%b rdata=%0d want 1 0 10", i, a_rvalid, a_arready, a_rdata);
            end
            @(posedge clock); #1;
        end
        a_rready = 1'b1;
        @(posedge clock); #1;
        a_rready = 1'b0;
        n_compared++;
        if ({a_rvalid, a_arready} !== 2'b01) begin n_mismatched++; $display("[TB] FAIL stall_no_bypass: got rvalid=%b arready=%b want 0 1", a_rvalid, a_arready); end
        @(posedge clock); #1;
        a_arvalid = 1'b0;
        n_compared++;
        if ({a_rvalid, a_rdata} !== {1'b1, 64'd17}) begin n_mismatched++; $display("[TB] FAIL stall_second_read: got rvalid=%b rdata=%0d want 1 17", a_rvalid, a_rdata); end
        a_rready = 1'b1;
        @(posedge clock); #1;
        a_rready = 1'b0;
    endtask

    task automatic test_prescaler();
        do_reset();
        wait_cycle(7);
        b_araddr = ADDR_HI; b_arvalid = 1'b1;
        @(posedge clock); #1;
        b_arvalid = 1'b0;
        n_compared++;
        if ({b_rvalid, b_rresp, b_rdata} !== {1'b1, 2'b00, 64'd1}) begin n_mismatched++; $display("[TB] FAIL div4_read_c7: got rvalid=%b rresp=%b rdata=%0d want 1 00 1", b_rvalid, b_rresp, b_rdata); end
        b_rready = 1'b1;
        @(posedge clock); #1;
        b_rready = 1'b0;
        wait_cycle(13);
        b_arvalid = 1'b1;
        @(posedge clock); #1;
        b_arvalid = 1'b0;
        n_compared++;
        if ({b_rvalid, b_rresp, b_rdata} !== {1'b1, 2'b00, 64'd3}) begin n_mismatched++; $display("[TB] FAIL div4_read_c13: got rvalid=%b rresp=%b rdata=%0d want 1 00 3", b_rvalid, b_rresp, b_rdata); end
        b_rready = 1'b1;
        @(posedge clock); #1;
        b_rready = 1'b0;
    endtask

    task automatic test_bad_offset();
        a_rready = 1'b1;
        @(posedge clock); #1;
        a_rready = 1'b0;
        n_compared++;
        if ({a_rvalid, a_arready} !== 2'b01) begin n_mismatched++; $display("[TB] FAIL idle_rready_ignored: got rvalid=%b arready=%b want 0 1", a_rvalid, a_arready); end
        a_araddr = ADDR_BAD; a_arvalid = 1'b1;
        @(posedge clock); #1;
        a_arvalid = 1'b0;
        n_compared++;
        if ({a_rvalid, a_rresp, a_rlast} !== 4'b1_10_1) begin n_mismatched++; $display("[TB] FAIL bad_resp: got rvalid=%b rresp=%b rlast=%b want 1 10 1", a_rvalid, a_rresp, a_rlast); end
        n_compared++;
        if (a_rdata !== 64'h0) begin n_mismatched++; $display("[TB] FAIL bad_rdata: got %h want 0", a_rdata); end
        a_rready = 1'b1;
        @(posedge clock); #1;
        a_rready = 1'b0;
        n_compared++;
        if ({a_rvalid, a_arready, a_rresp} !== 4'b01_00) begin n_mismatched++; $display("[TB] FAIL bad_back_to_idle: got rvalid=%b arready=%b rresp=%b want 0 1 00", a_rvalid, a_arready, a_rresp); end
    endtask

    task automatic test_wrap();
        logic [63:0] want [3];
        want[0] = 64'hFFFF_FFFF_FFFF_FFFE;
        want[1] = 64'h0;
        want[2] = 64'h2;
        force dut1.u_mtime.mtime = 64'hFFFF_FFFF_FFFF_FFFE;
        #1 release dut1.u_mtime.mtime;
        a_araddr = ADDR_LO;
        for (int i = 0; i < 3; i++) begin
            a_arvalid = 1'b1;
            @(posedge clock); #1;
            a_arvalid = 1'b0;
            n_compared++;
            if ({a_rvalid, a_rresp, a_rdata} !== {1'b1, 2'b00, want[i]}) begin
                n_mismatched++;
                $display("[TB] FAIL wrap_read_%0d: got rvalid=%b rresp=%b rdata=%h want 1 00 %h", i, a_rvalid, a_rresp, a_rdata, want[i]);
            end
            a_rready = 1'b1;
            @(posedge clock); #1;
            a_rready = 1'b0;
        end
    endtask

    task automatic test_reset_mid_response();
        a_araddr = ADDR_LO; a_arvalid = 1'b1;
        @(posedge clock); #1;
        a_arvalid = 1'b0;
        n_compared++;
        if (a_rvalid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL midreset_pre_rvalid: got %b want 1", a_rvalid); end
        reset = 1'b0;
        #1;
        n_compared++;
        if ({a_rvalid, a_arready, a_rdata} !== {2'b01, 64'h0}) begin n_mismatched++; $display("[TB] FAIL midreset_drop: got rvalid=%b arready=%b rdata=%h want 0 1 0", a_rvalid, a_arready, a_rdata); end
        n_compared++;
        if (dut1.u_mtime.mtime !== 64'h0) begin n_mismatched++; $display("[TB] FAIL midreset_mtime: got %h want 0", dut1.u_mtime.mtime); end
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        n_compared++;
        if ({a_rvalid, a_arready} !== 2'b01) begin n_mismatched++; $display("[TB] FAIL midreset_no_owed: got rvalid=%b arready=%b want 0 1", a_rvalid, a_arready); end
        wait_cycle(5);
        a_arvalid = 1'b1;
        @(posedge clock); #1;
        a_arvalid = 1'b0;
        n_compared++;
        if ({a_rvalid, a_rresp, a_rdata} !== {1'b1, 2'b00, 64'd5}) begin n_mismatched++; $display("[TB] FAIL midreset_elapsed: got rvalid=%b rresp=%b rdata=%0d want 1 00 5", a_rvalid, a_rresp, a_rdata); end
        a_rready = 1'b1;
        @(posedge clock); #1;
        a_rready = 1'b0;
    endtask

    initial begin
        $display("[TB] clint directed bench start");
        test_reset();
        test_single_read();
        test_stall();
        test_prescaler();
        test_bad_offset();
        test_wrap();
        test_reset_mid_response();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
